rssi_agc_ctrl: RTL and testbench

RSSI_AGC_CTRL -- requirements
Module: rssi_agc_ctrl

---
 rtl/rssi_agc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_rssi_agc_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rssi_agc_ctrl.sv
// rssi_agc_ctrl: window pulse generator, power result capture, log2 RSSI estimate
// and a hysteretic gain-code loop with saturation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for the next window boundary pulse
// WAIT_RES | window closed; waiting for the power result, with timeout
// CALC     | captured power converted to log2; first result dropped
// ADJ      | gain code stepped up/down/held against target +/- hyst
module rssi_agc_ctrl #(
  parameter int CLK_PER_WIN = 500000,
  parameter int TIMEOUT     = 64,
  parameter int GAIN_WIDTH  = 6,
  parameter int GAIN_INIT   = 32,
  parameter int GAIN_MAX    = 63
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  output logic                  o_syn_10ms,
  input  logic                  i_syn_flag,
  input  logic [25:0]           i_pow_sum,
  input  logic [6:0]            i_target_log,
  input  logic [2:0]            i_hyst,
  output logic [6:0]            o_rssi_log,
  output logic                  o_rssi_vld,
  output logic [GAIN_WIDTH-1:0] o_gain,
  output logic                  o_gain_upd,
  output logic                  o_timeout
);

  localparam int WIN_W = $clog2(CLK_PER_WIN + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [WIN_W-1:0]      WIN_LAST = WIN_W'(CLK_PER_WIN - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAIN_WIDTH-1:0] G_MAX    = GAIN_WIDTH'(GAIN_MAX);
  localparam logic [GAIN_WIDTH-1:0] G_INIT   = GAIN_WIDTH'(GAIN_INIT);

  typedef enum logic [1:0] {IDLE, WAIT_RES, CALC, ADJ} state_t;

  state_t           state, state_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [25:0]      pow_cap;
  logic             discard;
  logic             capture;
  logic             publish;
  logic             drop_first;
  logic             adj_en;
  logic [6:0]       rssi_calc;
  logic signed [7:0] rssi_s, lo_s, hi_s;

  // Leading-one index as integer part, the two bits below it as fraction.
  function automatic logic [6:0] log2_est(input logic [25:0] v);
    logic [4:0]  idx;
    logic [27:0] ext;
    logic [1:0]  frac;
    idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (v[i]) idx = 5'(i);
    end
    // two zero bits appended so indices 0 and 1 pull in zeros below bit 0
    ext  = {v, 2'b00};
    frac = 2'(ext >> idx);
    return {idx, frac};
  endfunction

  assign rssi_calc = log2_est(pow_cap);
  assign rssi_s    = signed'({1'b0, o_rssi_log});
  assign lo_s      = signed'({1'b0, i_target_log}) - signed'({5'b0, i_hyst});
  assign hi_s      = signed'({1'b0, i_target_log}) + signed'({5'b0, i_hyst});
  assign o_syn_10ms = i_en && (win_cnt == WIN_LAST);

  // Window must outlast the longest result wait so the pulse always lands in IDLE.
  always_ff @(posedge i_clk) begin
    param_chk: assert (CLK_PER_WIN > TIMEOUT + 4)
      else $error("rssi_agc_ctrl: CLK_PER_WIN must exceed TIMEOUT+4");
  end

  // Free-running window counter, cleared while disabled.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) win_cnt <= '0;
    else if (win_cnt == WIN_LAST) win_cnt <= '0;
    else win_cnt <= win_cnt + WIN_W'(1);
  end

  // Result wait timer, only runs in WAIT_RES.
  always_ff @(posedge i_clk) begin
    if (i_rst || state != WAIT_RES) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    publish    = 1'b0;
    drop_first = 1'b0;
    adj_en     = 1'b0;
    o_timeout  = 1'b0;
    case (state)
      IDLE:     if (o_syn_10ms) state_nxt = WAIT_RES;
      WAIT_RES: begin
        // a flag arriving in the terminal-count cycle still counts as a result
        if (i_syn_flag) begin
          capture   = 1'b1;
          state_nxt = CALC;
        end else if (tmo_cnt == TMO_LAST) begin
          o_timeout = 1'b1;
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (discard) begin
          drop_first = 1'b1;
          state_nxt  = IDLE;
        end else begin
          publish   = 1'b1;
          state_nxt = ADJ;
        end
      end
      ADJ: begin
        adj_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!i_en || i_rst) begin
      state_nxt  = IDLE;
      capture    = 1'b0;
      publish    = 1'b0;
      drop_first = 1'b0;
      adj_en     = 1'b0;
      o_timeout  = 1'b0;
    end
  end

  // Capture, RSSI publish, discard tracking and gain adjustment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pow_cap    <= '0;
      o_rssi_log <= '0;
      o_rssi_vld <= 1'b0;
      o_gain     <= G_INIT;
      o_gain_upd <= 1'b0;
      discard    <= 1'b1;
    end else begin
      o_rssi_vld <= 1'b0;
      o_gain_upd <= 1'b0;
      if (!i_en) discard <= 1'b1;
      if (capture) pow_cap <= i_pow_sum;
      if (drop_first) discard <= 1'b0;
      if (publish) begin
        o_rssi_log <= rssi_calc;
        o_rssi_vld <= 1'b1;
      end
      if (adj_en) begin
        if (rssi_s < lo_s && o_gain != G_MAX) begin
          o_gain     <= o_gain + GAIN_WIDTH'(1);
          o_gain_upd <= 1'b1;
        end else if (rssi_s > hi_s && o_gain != '0) begin
          o_gain     <= o_gain - GAIN_WIDTH'(1);
          o_gain_upd <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rssi_agc_ctrl.sv
// Directed bench for rssi_agc_ctrl with an expected-RSSI scoreboard queue and
// an independent gain model.
module tb_rssi_agc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        syn_flag = 1'b0;
  logic [25:0] pow_sum = '0;
  logic [6:0]  target_log = 7'd60;
  logic [2:0]  hyst = 3'd2;
  logic        syn_10ms;
  logic [6:0]  rssi_log;
  logic        rssi_vld;
  logic [5:0]  gain;
  logic        gain_upd;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int syn_last = -1;
  int syn_prev = -1;
  int g_model = 32;
  logic [6:0] exp_q[$];

  rssi_agc_ctrl #(
    .CLK_PER_WIN(100), .TIMEOUT(16), .GAIN_WIDTH(6), .GAIN_INIT(32), .GAIN_MAX(63)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_syn_10ms(syn_10ms),
    .i_syn_flag(syn_flag), .i_pow_sum(pow_sum), .i_target_log(target_log),
    .i_hyst(hyst), .o_rssi_log(rssi_log), .o_rssi_vld(rssi_vld),
    .o_gain(gain), .o_gain_upd(gain_upd), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (syn_10ms) begin
      syn_prev = syn_last;
      syn_last = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic wait_syn(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (syn_10ms) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("syn_10ms_seen", 0, 1);
  endtask

  // One window: result delivered dly cycles after the window pulse.
  task automatic measure(input logic [25:0] pow, input logic [6:0] exp_rssi,
                         input bit exp_vld, input int dly, input string tag);
    bit ok;
    int exp_upd;
    logic [6:0] got;
    wait_syn(ok);
    if (!ok) return;
    for (int i = 0; i < dly; i++) @(negedge clk);
    syn_flag = 1'b1;
    pow_sum  = pow;
    if (exp_vld) exp_q.push_back(exp_rssi);
    #1;
    chk({tag, "_no_timeout"}, timeout, 0);
    @(negedge clk);
    syn_flag = 1'b0;
    pow_sum  = '0;
    chk({tag, "_vld_early"}, rssi_vld, 0);
    @(negedge clk);
    chk({tag, "_vld"}, rssi_vld, exp_vld);
    if (rssi_vld) begin
      chk({tag, "_q_nonempty"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk({tag, "_rssi"}, rssi_log, got);
      end
    end
    exp_upd = 0;
    if (exp_vld) begin
      if (int'(exp_rssi) < int'(target_log) - int'(hyst) && g_model < 63) begin
        g_model++;
        exp_upd = 1;
      end else if (int'(exp_rssi) > int'(target_log) + int'(hyst) && g_model > 0) begin
        g_model--;
        exp_upd = 1;
      end
    end
    @(negedge clk);
    chk({tag, "_gain"}, gain, g_model);
    chk({tag, "_gain_upd"}, gain_upd, exp_upd);
    chk({tag, "_vld_once"}, rssi_vld, 0);
  endtask

  initial begin
    bit ok;
    int c0;
    int tseen;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_gain", gain, 32);
    chk("rst_rssi", rssi_log, 0);
    chk("rst_vld", rssi_vld, 0);
    chk("rst_upd", gain_upd, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_syn", syn_10ms, 0);
    rst = 1'b0;
    en  = 1'b1;

    // first result discarded, then conversions and gain steps
    measure(26'h400, 7'd0, 0, 3, "discard0");
    measure(26'h400, 7'd40, 1, 3, "r40");
    measure(26'h30000, 7'd70, 1, 3, "r70a");
    measure(26'h7000, 7'd59, 1, 3, "r59");
    measure(26'h30000, 7'd70, 1, 3, "r70b");
    chk("period_run", syn_last - syn_prev, 100);
    measure(26'h600, 7'd42, 1, 3, "r42");
    measure(26'h0, 7'd0, 1, 3, "r0");
    measure(26'h3FFFFFF, 7'd103, 1, 3, "r103");
    // flag in the terminal-count cycle wins over timeout
    measure(26'h400, 7'd40, 1, 16, "race");
    measure(26'h3FFFFFF, 7'd103, 1, 3, "back");

    // timeout
    wait_syn(ok);
    c0 = cyc;
    tseen = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("tmo_no_vld", rssi_vld, 0);
      if (timeout) begin
        tseen = cyc;
        break;
      end
    end
    chk("tmo_delay", tseen - c0, 16);
    @(negedge clk);
    chk("tmo_pulse_once", timeout, 0);
    chk("tmo_gain", gain, g_model);
    measure(26'h400, 7'd40, 1, 3, "after_tmo");

    // enable toggle: first result discarded, period 100
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("dis_syn", syn_10ms, 0);
    en = 1'b1;
    measure(26'h400, 7'd0, 0, 3, "en_discard");
    measure(26'h400, 7'd40, 1, 3, "en_first");
    chk("period_en", syn_last - syn_prev, 100);

    // saturation high
    while (g_model < 63) measure(26'h400, 7'd40, 1, 3, "climb");
    measure(26'h400, 7'd40, 1, 3, "sat_hi");
    // saturation low
    while (g_model > 0) measure(26'h3FFFFFF, 7'd103, 1, 3, "fall");
    measure(26'h3FFFFFF, 7'd103, 1, 3, "sat_lo");

    // reset in WAIT_RES
    wait_syn(ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    g_model = 32;
    chk("mid_rst_gain", gain, 32);
    chk("mid_rst_rssi", rssi_log, 0);
    chk("mid_rst_vld", rssi_vld, 0);
    chk("mid_rst_upd", gain_upd, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_syn", syn_10ms, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("mid_rst_quiet", rssi_vld | gain_upd | timeout, 0);
    end
    measure(26'h400, 7'd0, 0, 3, "rst_discard");
    measure(26'h400, 7'd40, 1, 3, "rst_first");
    chk("q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
